// File: rtl/psk_symbol_detector_if.sv
// psk_symbol_detector_if
// Groups the sample streams and the symbol output stream of the PSK symbol
// detector into one bundle.
//   I_tdata/I_tvalid   : signed in-phase sample stream
//   Q_tdata/Q_tvalid   : signed quadrature sample stream
//   sym_tdata/sym_tvalid/sym_tready : decided symbol stream {I_bit, Q_bit}
// Modports:
//   master : the side that produces samples and consumes symbols
//   slave  : the detector itself
interface psk_symbol_detector_if #(
  parameter int WIDTH = 16
) ();
  logic signed [WIDTH-1:0] I_tdata;
  logic                    I_tvalid;
  logic signed [WIDTH-1:0] Q_tdata;
  logic                    Q_tvalid;
  logic [1:0]              sym_tdata;
  logic                    sym_tvalid;
  logic                    sym_tready;

  modport master (
    output I_tdata, I_tvalid, Q_tdata, Q_tvalid, sym_tready,
    input  sym_tdata, sym_tvalid
  );

  modport slave (
    input  I_tdata, I_tvalid, Q_tdata, Q_tvalid, sym_tready,
    output sym_tdata, sym_tvalid
  );
endinterface

// File: rtl/psk_symbol_detector.sv
// psk_symbol_detector
// Integrate-and-dump BPSK/QPSK symbol slicer. I and Q samples are summed over
// SPS accepted samples; on the last sample of a symbol (DUMP) the signs of
// the two totals form the symbol, which is placed in a held output register
// with a valid/ready handshake.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   bus       : psk_symbol_detector_if.slave (sample inputs, symbol output)
//   mode      : 0 = BPSK, 1 = QPSK; only looked at on the DUMP sample
//   sync      : restart the symbol phase (partial sums discarded)
//   sym_count : symbols loaded into the output register, wraps at 16 bits
//   overrun   : sticky, a symbol was dropped because the output was full
//   squelched : one-cycle pulse, a low-energy symbol was suppressed
// Optional feature: define PSK_DET_SQUELCH_EN to enable the magnitude squelch
// (|accI| + |accQ| < SQ_THRESH suppresses the symbol). Without it squelched
// is tied low and no metric logic is built.
module psk_symbol_detector #(
  parameter int WIDTH     = 16,
  parameter int SPS       = 4,
  parameter int SQ_THRESH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  psk_symbol_detector_if.slave  bus,
  input  logic                  mode,
  input  logic                  sync,
  output logic [15:0]           sym_count,
  output logic                  overrun,
  output logic                  squelched
);

  localparam int ACC_W = WIDTH + $clog2(SPS);
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  // The phase counter is the block's state; ACCUM/DUMP is decoded from it.
  typedef enum logic {ACCUM, DUMP} phase_t;

  logic             accept;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_base;
  phase_t           phase;
  logic             dump;

  logic signed [WIDTH-1:0] sample [2];
  logic signed [ACC_W-1:0] total  [2];

  logic       squelch_hit;
  logic       load;
  logic       drop;
  logic [1:0] sym_data_next;
  logic [1:0] sym_data_reg;
  logic       sym_valid_reg;
  logic [15:0] sym_count_reg;
  logic       overrun_reg;

  assign accept    = bus.I_tvalid && bus.Q_tvalid;
  assign sample[0] = bus.I_tdata;
  assign sample[1] = bus.Q_tdata;

  // sync acts combinationally so a sample arriving with it starts the new
  // symbol instead of landing in the old one.
  assign cnt_base = sync ? '0 : cnt_reg;
  assign phase    = (cnt_base == LAST) ? DUMP : ACCUM;
  assign dump     = accept && (phase == DUMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= dump ? '0 : cnt_base + CNT_W'(1);
    end else if (sync) begin
      cnt_reg <= '0;
    end
  end

`ifdef PSK_DET_SQUELCH_EN
  logic [ACC_W:0] abs_val [2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] acc_base;

      assign acc_base  = sync ? '0 : acc_reg;
      // Size cast of a signed operand sign-extends into the accumulator.
      assign total[gi] = acc_base + ACC_W'(sample[gi]);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_reg <= '0;
        end else if (accept) begin
          acc_reg <= dump ? '0 : total[gi];
        end else if (sync) begin
          acc_reg <= '0;
        end
      end

`ifdef PSK_DET_SQUELCH_EN
      // One extra bit so that the magnitude of the most negative total fits.
      logic [ACC_W:0] ext;
      assign ext         = {total[gi][ACC_W-1], total[gi]};
      assign abs_val[gi] = total[gi][ACC_W-1] ? (ACC_W+1)'(-ext) : ext;
`endif
    end
  endgenerate

`ifdef PSK_DET_SQUELCH_EN
  localparam logic [31:0] SQ_LIM = 32'(SQ_THRESH);
  logic [ACC_W:0] metric;
  logic [31:0]    metric_ext;
  logic           squelched_reg;

  assign metric      = abs_val[0] + abs_val[1];
  assign metric_ext  = 32'(metric);
  assign squelch_hit = dump && (metric_ext < SQ_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squelched_reg <= 1'b0;
    end else begin
      squelched_reg <= squelch_hit;
    end
  end

  assign squelched = squelched_reg;
`else
  logic unused_sq_thresh;
  assign unused_sq_thresh = SQ_THRESH[0];
  assign squelch_hit      = 1'b0;
  assign squelched        = 1'b0;
`endif

  // Sign bit of the total is the decision; a zero total has sign 0.
  assign sym_data_next = {total[0][ACC_W-1], mode & total[1][ACC_W-1]};

  // Free slot: empty now, or the held symbol leaves in this cycle.
  assign load = dump && !squelch_hit && (!sym_valid_reg || bus.sym_tready);
  assign drop = dump && !squelch_hit && sym_valid_reg && !bus.sym_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_data_reg  <= 2'b00;
      sym_valid_reg <= 1'b0;
      sym_count_reg <= 16'd0;
      overrun_reg   <= 1'b0;
    end else begin
      if (load) begin
        sym_data_reg  <= sym_data_next;
        sym_valid_reg <= 1'b1;
        sym_count_reg <= sym_count_reg + 16'd1;
      end else if (sym_valid_reg && bus.sym_tready) begin
        sym_valid_reg <= 1'b0;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.sym_tdata  = sym_data_reg;
  assign bus.sym_tvalid = sym_valid_reg;
  assign sym_count      = sym_count_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_psk_symbol_detector.sv
module tb_psk_symbol_detector;

  localparam int WIDTH     = 16;
  localparam int SPS       = 4;
  localparam int SQ_THRESH = 64;
`ifdef PSK_DET_SQUELCH_EN
  localparam bit SQ_ON = 1'b1;
`else
  localparam bit SQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode = 1'b0;
  logic sync = 1'b0;
  logic [15:0] sym_count;
  logic overrun;
  logic squelched;

  psk_symbol_detector_if #(.WIDTH(WIDTH)) bus ();

  psk_symbol_detector #(.WIDTH(WIDTH), .SPS(SPS), .SQ_THRESH(SQ_THRESH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mode(mode), .sync(sync),
    .sym_count(sym_count), .overrun(overrun), .squelched(squelched)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer sums of the current symbol's samples.
  int          m_phase, m_si, m_sq;
  logic [1:0]  m_data;
  logic        m_valid;
  logic [15:0] m_count;
  logic        m_ovr, m_sqp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_si = 0; m_sq = 0;
    m_data = 2'b00; m_valid = 1'b0; m_count = 16'd0; m_ovr = 1'b0; m_sqp = 1'b0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int ii, qq, mag_i, mag_q;
    bit accept, hs, load;
    logic [1:0] nd;
    ii = $signed(bus.I_tdata);
    qq = $signed(bus.Q_tdata);
    accept = bus.I_tvalid && bus.Q_tvalid;
    hs = m_valid && bus.sym_tready;
    load = 1'b0;
    nd = 2'b00;
    m_sqp = 1'b0;
    if (sync) begin m_phase = 0; m_si = 0; m_sq = 0; end
    if (accept) begin
      m_si += ii; m_sq += qq; m_phase++;
      if (m_phase == SPS) begin
        nd = {m_si < 0, mode && (m_sq < 0)};
        mag_i = (m_si < 0) ? -m_si : m_si;
        mag_q = (m_sq < 0) ? -m_sq : m_sq;
        if (SQ_ON && (mag_i + mag_q < SQ_THRESH)) m_sqp = 1'b1;
        else if (m_valid && !bus.sym_tready) m_ovr = 1'b1;
        else load = 1'b1;
        m_phase = 0; m_si = 0; m_sq = 0;
      end
    end
    if (load) begin m_data = nd; m_valid = 1'b1; m_count++; end
    else if (hs) m_valid = 1'b0;
  endtask

  function automatic logic [31:0] dut_outs();
    return 32'({bus.sym_tdata, bus.sym_tvalid, sym_count, overrun, squelched});
  endfunction

  function automatic logic [31:0] model_outs();
    return 32'({m_data, m_valid, m_count, m_ovr, m_sqp});
  endfunction

  task automatic step(input string name);
    if (bus.sym_tvalid && bus.sym_tready)
      $display("txn: symbol=%b count=%0d t=%0t", bus.sym_tdata, sym_count, $time);
    model_step();
    @(posedge clk);
    #1;
    chk(name, dut_outs(), model_outs());
  endtask

  task automatic set_sample(input int i, input int q);
    bus.I_tdata = 16'(i); bus.Q_tdata = 16'(q);
    bus.I_tvalid = 1'b1; bus.Q_tvalid = 1'b1;
  endtask

  task automatic idle();
    bus.I_tvalid = 1'b0; bus.Q_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle(); sync = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_state", dut_outs(), 32'd0);
    rst = 1'b1;
  endtask

  typedef struct {
    string name;
    bit    mode;
    int    i [4];
    int    q [4];
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bus.I_tdata = '0; bus.Q_tdata = '0; idle(); bus.sym_tready = 1'b1;

    vecs[0] = '{"qpsk_p1000_m1000", 1'b1, '{1000, 1000, 1000, 1000}, '{-1000, -1000, -1000, -1000}, 2'b01};
    vecs[1] = '{"bpsk_m500_p700", 1'b0, '{-500, -500, -500, -500}, '{700, 700, 700, 700}, 2'b10};
    vecs[2] = '{"qpsk_sum_m100", 1'b1, '{100, 100, 100, -400}, '{1, 1, 1, 1}, 2'b10};
    vecs[3] = '{"qpsk_zero_total", 1'b1, '{1, -1, 1, -1}, '{-3000, -3000, -3000, -3000}, 2'b01};
    vecs[4] = '{"qpsk_full_scale", 1'b1, '{-32768, -32768, -32768, -32768}, '{32767, 32767, 32767, 32767}, 2'b10};
    vecs[5] = '{"bpsk_q_negative", 1'b0, '{2000, 2000, 2000, 2000}, '{-2000, -2000, -2000, -2000}, 2'b00};

    // Single symbols from the table, ready held high.
    foreach (vecs[v]) begin
      do_reset();
      mode = vecs[v].mode;
      bus.sym_tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        set_sample(vecs[v].i[k], vecs[v].q[k]);
        step(vecs[v].name);
      end
      idle();
      chk({vecs[v].name, "_valid"}, 32'(bus.sym_tvalid), 32'd1);
      chk({vecs[v].name, "_data"}, 32'(bus.sym_tdata), 32'(vecs[v].exp));
      chk({vecs[v].name, "_count"}, 32'(sym_count), 32'd1);
    end

    // Two symbols with downstream stalled: second one is dropped.
    do_reset();
    mode = 1'b1; bus.sym_tready = 1'b0;
    for (int k = 0; k < 8; k++) begin set_sample(1000, 1000); step("stall_seq"); end
    idle();
    chk("stall_data", 32'(bus.sym_tdata), 32'd0);
    chk("stall_overrun", 32'(overrun), 32'd1);
    chk("stall_count", 32'(sym_count), 32'd1);
    bus.sym_tready = 1'b1;
    step("stall_release");
    chk("stall_one_handshake", 32'(bus.sym_tvalid), 32'd0);
    step("stall_after");
    chk("stall_still_empty", 32'(bus.sym_tvalid), 32'd0);

    // sync with the 3rd sample restarts the symbol.
    do_reset();
    mode = 1'b1; bus.sym_tready = 1'b1;
    set_sample(1000, 1000); step("sync_s1");
    set_sample(1000, 1000); step("sync_s2");
    set_sample(1000, 1000); sync = 1'b1; step("sync_s3"); sync = 1'b0;
    chk("sync_no_early_valid0", 32'(bus.sym_tvalid), 32'd0);
    set_sample(1000, 1000); step("sync_s4");
    chk("sync_no_early_valid1", 32'(bus.sym_tvalid), 32'd0);
    set_sample(1000, 1000); step("sync_s5");
    chk("sync_no_early_valid2", 32'(bus.sym_tvalid), 32'd0);
    set_sample(-1000, 1000); step("sync_s6");
    chk("sync_dump_valid", 32'(bus.sym_tvalid), 32'd1);
    chk("sync_dump_data", 32'(bus.sym_tdata), 32'd0);

    // Reset in the middle of a symbol: asynchronous clear, phase restarts.
    set_sample(-1000, -1000); step("mid_s1");
    set_sample(-1000, -1000); step("mid_s2");
    idle();
    rst = 1'b0;
    #1;
    chk("mid_reset_async_clear", dut_outs(), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin set_sample(-1000, -1000); step("mid_restart"); end
    chk("mid_restart_not_yet", 32'(bus.sym_tvalid), 32'd0);
    set_sample(-1000, -1000); step("mid_restart_dump");
    chk("mid_restart_data", 32'(bus.sym_tdata), 32'd3);

    // Low-energy symbol: suppressed with squelch, emitted without it.
    do_reset();
    mode = 1'b1; bus.sym_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin set_sample(4, 4); step("low_energy"); end
    idle();
    chk("low_energy_squelched", 32'(squelched), SQ_ON ? 32'd1 : 32'd0);
    chk("low_energy_valid", 32'(bus.sym_tvalid), SQ_ON ? 32'd0 : 32'd1);
    chk("low_energy_count", 32'(sym_count), SQ_ON ? 32'd0 : 32'd1);
    step("low_energy_after");
    chk("low_energy_pulse_ends", 32'(squelched), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.I_tvalid = ($urandom_range(0, 99) < 85);
      bus.Q_tvalid = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 3) == 0) begin
        bus.I_tdata = 16'(int'($urandom_range(0, 20)) - 10);
        bus.Q_tdata = 16'(int'($urandom_range(0, 20)) - 10);
      end else begin
        bus.I_tdata = 16'($urandom);
        bus.Q_tdata = 16'($urandom);
      end
      sync = ($urandom_range(0, 99) < 3);
      mode = 1'($urandom);
      bus.sym_tready = ($urandom_range(0, 99) < 70);
      step("random");
    end
    sync = 1'b0; idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
